// File: rtl/mod_mul_radix4.sv
// ---------------------------------------------------------------------------
// mod_mul_radix4 : iterative radix-4 modular multiplier, oData = (iA*iB) mod iQ
//
// The multiplicand is scanned two bits per cycle, MSB first, with
// acc = (4*acc + digit*B) mod Q. The digit multiples M0..M3 are prepared in
// two setup cycles (PRE2, PRE3), then one ITER cycle is spent per digit.
// Valid/ready handshake on both sides; no overlap between operations.
//
// Optional build macro: MOD_MUL_RANGE_CHECK_EN
//   Adds output oErr. Operands with iA>=iQ, iB>=iQ or iQ<2 skip the
//   computation and complete one edge after accept with oData=0, oErr=1.
// Operand width is the BITWIDTH parameter, default 16.
// ---------------------------------------------------------------------------
module mod_mul_radix4 #(
   parameter int BITWIDTH = 16
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iValid,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iA,
   input  logic [BITWIDTH-1:0] iB,
   input  logic [BITWIDTH-1:0] iQ,
   output logic                oValid,
   input  logic                iReady,
`ifdef MOD_MUL_RANGE_CHECK_EN
   output logic                oErr,
`endif
   output logic [BITWIDTH-1:0] oData
);

   localparam int DIGITS = (BITWIDTH + 1) / 2;
   localparam int AW     = 2 * DIGITS;               // A zero-extended to whole digits
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE2,
      S_PRE3,
      S_ITER,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [AW-1:0]       r_a;
   logic [BITWIDTH-1:0] r_b;
   logic [BITWIDTH-1:0] r_q;
   logic [BITWIDTH-1:0] r_m2;
   logic [BITWIDTH-1:0] r_m3;
   logic [BITWIDTH-1:0] r_acc;
   logic [CW-1:0]       r_cnt;
   logic [BITWIDTH-1:0] r_data;

   logic                w_accept;
   logic                w_last;
   logic                w_illegal;

   // ------------------------------------------------------------------------
   // Operand range check (only meaningful when the feature is built in)
   // ------------------------------------------------------------------------
`ifdef MOD_MUL_RANGE_CHECK_EN
   logic r_err;
   assign w_illegal = (iA >= iQ) || (iB >= iQ) || (iQ < BITWIDTH'(2));
   assign oErr      = r_err;
`else
   assign w_illegal = 1'b0;
`endif

   assign w_accept = iValid && (r_state == S_IDLE);
   assign w_last   = (r_cnt == '0);

   // ------------------------------------------------------------------------
   // Modular arithmetic datapath
   // ------------------------------------------------------------------------
   // M2 = 2B mod Q with one conditional subtract at BITWIDTH+1 bits.
   logic [BITWIDTH:0]   w_b2;
   logic [BITWIDTH:0]   w_m2_full;
   logic [BITWIDTH-1:0] w_m2;
   assign w_b2      = {r_b, 1'b0};
   assign w_m2_full = (w_b2 >= {1'b0, r_q}) ? (w_b2 - {1'b0, r_q}) : w_b2;
   assign w_m2      = BITWIDTH'(w_m2_full);

   // M3 = (M2 + B) mod Q.
   logic [BITWIDTH:0]   w_m3_sum;
   logic [BITWIDTH:0]   w_m3_full;
   logic [BITWIDTH-1:0] w_m3;
   assign w_m3_sum  = {1'b0, r_m2} + {1'b0, r_b};
   assign w_m3_full = (w_m3_sum >= {1'b0, r_q}) ? (w_m3_sum - {1'b0, r_q}) : w_m3_sum;
   assign w_m3      = BITWIDTH'(w_m3_full);

   // t = (4*acc) mod Q: acc < Q so 4*acc < 4Q and three subtracts suffice.
   logic [BITWIDTH+1:0] w_q_ext;
   logic [BITWIDTH+1:0] w_t0;
   logic [BITWIDTH+1:0] w_t1;
   logic [BITWIDTH+1:0] w_t2;
   logic [BITWIDTH+1:0] w_t3;
   logic [BITWIDTH-1:0] w_t;
   assign w_q_ext = {2'b00, r_q};
   assign w_t0    = {r_acc, 2'b00};
   assign w_t1    = (w_t0 >= w_q_ext) ? (w_t0 - w_q_ext) : w_t0;
   assign w_t2    = (w_t1 >= w_q_ext) ? (w_t1 - w_q_ext) : w_t1;
   assign w_t3    = (w_t2 >= w_q_ext) ? (w_t2 - w_q_ext) : w_t2;
   assign w_t     = BITWIDTH'(w_t3);

   // Current digit selects one of the precomputed multiples.
   logic [1:0]          w_digit;
   logic [BITWIDTH-1:0] w_md;
   assign w_digit = r_a[2*r_cnt +: 2];

   // Digit-multiple table lookup
   always_comb begin
      // NOTE: every branch-assigned combinational signal gets a default first so no latch is inferred.
      w_md = '0;
      case (w_digit)
         2'd0:    w_md = '0;
         2'd1:    w_md = r_b;
         2'd2:    w_md = r_m2;
         default: w_md = r_m3;
      endcase
   end

   // s = (t + Md) mod Q.
   logic [BITWIDTH:0]   w_s_sum;
   logic [BITWIDTH:0]   w_s_full;
   logic [BITWIDTH-1:0] w_s;
   assign w_s_sum  = {1'b0, w_t} + {1'b0, w_md};
   assign w_s_full = (w_s_sum >= {1'b0, r_q}) ? (w_s_sum - {1'b0, r_q}) : w_s_sum;
   assign w_s      = BITWIDTH'(w_s_full);

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   // State register
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (iValid) begin
               w_state_next = w_illegal ? S_DONE : S_PRE2;
            end
         end
         S_PRE2:  w_state_next = S_PRE3;
         S_PRE3:  w_state_next = S_ITER;
         S_ITER: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (iReady) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign oReady = (r_state == S_IDLE);
   assign oValid = (r_state == S_DONE);
   assign oData  = r_data;

   // ------------------------------------------------------------------------
   // Datapath registers: operand capture, multiples, accumulator, result
   // ------------------------------------------------------------------------
   // Operand capture and per-state datapath updates
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         // NOTE: all datapath registers are reset so an aborted operation leaves no stale result visible.
         r_a    <= '0;
         r_b    <= '0;
         r_q    <= '0;
         r_m2   <= '0;
         r_m3   <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
`ifdef MOD_MUL_RANGE_CHECK_EN
         r_err  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a   <= AW'(iA);
                  r_b   <= iB;
                  r_q   <= iQ;
                  r_acc <= '0;
                  r_cnt <= CW'(DIGITS - 1);
`ifdef MOD_MUL_RANGE_CHECK_EN
                  r_err <= w_illegal;
                  if (w_illegal) begin
                     r_data <= '0;
                  end
`endif
               end
            end
            S_PRE2: r_m2 <= w_m2;
            S_PRE3: r_m3 <= w_m3;
            S_ITER: begin
               r_acc <= w_s;
               r_cnt <= r_cnt - CW'(1);
               if (w_last) begin
                  r_data <= w_s;
               end
            end
            S_DONE: begin
`ifdef MOD_MUL_RANGE_CHECK_EN
               if (iReady) begin
                  r_err <= 1'b0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_mul_radix4.sv
// ---------------------------------------------------------------------------
// tb_mod_mul_radix4 : self-checking bench for mod_mul_radix4 (BITWIDTH=16).
// Directed vectors plus randomized operands compared against a plain
// 64-bit arithmetic reference (a*b) % q. Handles MOD_MUL_RANGE_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_mod_mul_radix4;

   localparam int BW     = 16;
   localparam int DIGITS = (BW + 1) / 2;
   localparam int LAT    = DIGITS + 2;

   logic          iClk;
   logic          iRstN;
   logic          iValid;
   logic          oReady;
   logic [BW-1:0] iA;
   logic [BW-1:0] iB;
   logic [BW-1:0] iQ;
   logic          oValid;
   logic          iReady;
   logic [BW-1:0] oData;
`ifdef MOD_MUL_RANGE_CHECK_EN
   logic          oErr;
`endif

   int n_cmp;
   int n_err;

   mod_mul_radix4 #(.BITWIDTH(BW)) dut (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iValid (iValid),
      .oReady (oReady),
      .iA     (iA),
      .iB     (iB),
      .iQ     (iQ),
      .oValid (oValid),
      .iReady (iReady),
`ifdef MOD_MUL_RANGE_CHECK_EN
      .oErr   (oErr),
`endif
      .oData  (oData)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Global watchdog so the run can never hang.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference result from plain integer arithmetic.
   function automatic logic [BW-1:0] ref_mod_mul(input logic [BW-1:0] a,
                                                  input logic [BW-1:0] b,
                                                  input logic [BW-1:0] q);
      longint unsigned p;
      p = longint'(a) * longint'(b);
      return BW'(p % longint'(q));
   endfunction

   // One complete operation: offer, accept, wait for result, optional stall,
   // output handshake.
   task automatic run_op(input string tag,
                         input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [BW-1:0] q,
                         input int stall, input logic [BW-1:0] exp_data,
                         input int exp_lat, input logic exp_err);
      int waited;
      int lat;
      @(negedge iClk);
      iReady = (stall == 0);
      iA     = a;
      iB     = b;
      iQ     = q;
      iValid = 1'b1;
      waited = 0;
      while (!oReady && waited < 50) begin
         @(negedge iClk);
         waited++;
      end
      check({tag, "_ready"}, oReady, 1);
      @(posedge iClk);
      #1;
      // Scramble the inputs: the block must work from its captured copy.
      iValid = 1'b0;
      iA     = BW'($urandom);
      iB     = BW'($urandom);
      iQ     = BW'($urandom);
      lat    = 0;
      do begin
         @(posedge iClk);
         #1;
         lat++;
      end while (!oValid && lat < 60);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_data"}, oData, exp_data);
`ifdef MOD_MUL_RANGE_CHECK_EN
      check({tag, "_err"}, oErr, exp_err);
`else
      if (exp_err) $display("note: %s expects an error flag that this build lacks", tag);
`endif
      for (int i = 0; i < stall; i++) begin
         @(posedge iClk);
         #1;
         check({tag, "_hold_valid"}, oValid, 1);
         check({tag, "_hold_data"}, oData, exp_data);
         check({tag, "_hold_ready"}, oReady, 0);
         iValid = (i == 2);
         if (i == 2) begin
            iA = 16'd7;
            iB = 16'd8;
            iQ = 16'd11;
         end
      end
      iValid = 1'b0;
      iReady = 1'b1;
      @(posedge iClk);
      #1;
      check({tag, "_valid_clr"}, oValid, 0);
      check({tag, "_ready_back"}, oReady, 1);
`ifdef MOD_MUL_RANGE_CHECK_EN
      check({tag, "_err_clr"}, oErr, 0);
`endif
   endtask

   initial begin
      logic [BW-1:0] q;
      logic [BW-1:0] a;
      logic [BW-1:0] b;

      n_cmp  = 0;
      n_err  = 0;
      iRstN  = 1'b0;
      iValid = 1'b0;
      iReady = 1'b1;
      iA     = '0;
      iB     = '0;
      iQ     = '0;

      repeat (3) @(posedge iClk);
      #1;
      check("rst_ready", oReady, 1);
      check("rst_valid", oValid, 0);
      check("rst_data", oData, 0);
`ifdef MOD_MUL_RANGE_CHECK_EN
      check("rst_err", oErr, 0);
`endif
      @(negedge iClk);
      iRstN = 1'b1;

      // Directed vectors.
      run_op("basic", 16'd12345, 16'd54321, 16'd65521, 0, 16'd50831, LAT, 1'b0);
      run_op("max",   16'd65520, 16'd65520, 16'd65521, 0, 16'd1,     LAT, 1'b0);
      run_op("zero",  16'd0,     16'd40000, 16'd65521, 0, 16'd0,     LAT, 1'b0);
      run_op("q3",    16'd2,     16'd2,     16'd3,     0, 16'd1,     LAT, 1'b0);
      run_op("q2",    16'd1,     16'd1,     16'd2,     0, 16'd1,     LAT, 1'b0);
      run_op("stall", 16'd50,    16'd60,    16'd97,    6, 16'd90,    LAT, 1'b0);

      // Reset during the third ITER cycle aborts the operation.
      @(negedge iClk);
      iA     = 16'd12345;
      iB     = 16'd54321;
      iQ     = 16'd65521;
      iValid = 1'b1;
      @(posedge iClk);
      #1;
      iValid = 1'b0;
      repeat (4) @(posedge iClk);
      #1;
      check("midop_busy", oReady, 0);
      iRstN = 1'b0;
      #1;
      check("abort_valid", oValid, 0);
      check("abort_data", oData, 0);
      check("abort_ready", oReady, 1);
      @(negedge iClk);
      iRstN = 1'b1;
      run_op("after_rst", 16'd2, 16'd3, 16'd65521, 0, 16'd6, LAT, 1'b0);

`ifdef MOD_MUL_RANGE_CHECK_EN
      run_op("range_bad", 16'd100, 16'd5,  16'd100, 0, 16'd0, 1,   1'b1);
      run_op("range_ok",  16'd99,  16'd99, 16'd100, 0, 16'd1, LAT, 1'b0);
      run_op("range_q1",  16'd0,   16'd0,  16'd1,   2, 16'd0, 1,   1'b1);
`endif

      // Randomized legal operands against the reference model.
      for (int n = 0; n < 40; n++) begin
         q = BW'($urandom_range(65535, 2));
         a = BW'($urandom_range(int'(q) - 1, 0));
         b = BW'($urandom_range(int'(q) - 1, 0));
         run_op("rand", a, b, q, int'($urandom_range(3, 0)), ref_mod_mul(a, b, q), LAT, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
